// File: rtl/mips_pkg.sv
// Shared MIPS datapath widths used by the ID-stage immediate logic.
package mips_pkg;
   localparam int NB_IMM  = 16;
   localparam int NB_WORD = 32;
endpackage

// File: rtl/sign_ext_comb.sv
// Parameterised combinational sign extender: replicates the input MSB into the upper bits.
module sign_ext_comb #(
   parameter int NB_IN  = 16,
   parameter int NB_OUT = 32
) (
   input  logic [NB_IN-1:0]  value,
   output logic [NB_OUT-1:0] extended
);

   // Equal widths would need a zero-width replicate, so pass straight through instead.
   generate
      if (NB_OUT == NB_IN) begin : g_pass
         assign extended = value;
      end else begin : g_extend
         assign extended = {{(NB_OUT-NB_IN){value[NB_IN-1]}}, value};
      end
   endgenerate

endmodule

// File: rtl/ext_signo_unit.sv
// ID-stage immediate extender: sign/zero/LUI/branch variants plus a registered sign-extended copy.
module ext_signo_unit
   import mips_pkg::*;
#(
   parameter int NB_UNEXTEND = NB_IMM,
   parameter int NB_EXTEND   = NB_WORD
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic [NB_UNEXTEND-1:0] i_unextended,
   input  logic                   i_enable,
   output logic [NB_EXTEND-1:0]   o_extended,
   output logic [NB_EXTEND-1:0]   o_zero_extended,
   output logic [NB_EXTEND-1:0]   o_upper,
   output logic [NB_EXTEND-1:0]   o_branch_offset,
   output logic [NB_EXTEND-1:0]   o_extended_q,
   output logic                   o_valid_q
);

   generate
      if (NB_UNEXTEND < 1) begin : g_bad_in
         $error("ext_signo_unit: NB_UNEXTEND must be >= 1");
      end
      if (NB_EXTEND < NB_UNEXTEND) begin : g_bad_width
         $error("ext_signo_unit: NB_EXTEND must be >= NB_UNEXTEND");
      end
   endgenerate

   sign_ext_comb #(
      .NB_IN  (NB_UNEXTEND),
      .NB_OUT (NB_EXTEND)
   ) u_sign_ext (
      .value    (i_unextended),
      .extended (o_extended)
   );

   generate
      if (NB_EXTEND == NB_UNEXTEND) begin : g_same_width
         assign o_zero_extended = i_unextended;
         assign o_upper         = i_unextended;
      end else begin : g_wider
         assign o_zero_extended = {{(NB_EXTEND-NB_UNEXTEND){1'b0}}, i_unextended};
         assign o_upper         = {i_unextended, {(NB_EXTEND-NB_UNEXTEND){1'b0}}};
      end
   endgenerate

   // Word-aligned branch offset; the two MSBs shifted out are intentionally lost.
   assign o_branch_offset = o_extended << 2;

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         o_extended_q <= '0;
         o_valid_q    <= 1'b0;
      end else if (i_enable) begin
         o_extended_q <= o_extended;
         o_valid_q    <= 1'b1;
      end else begin
         o_valid_q    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ext_signo_unit.sv
// Self-checking bench for ext_signo_unit: directed vector table, register sequences, random sweep.
module tb_ext_signo_unit;

   logic        clock;
   logic        reset_n;
   logic [15:0] imm;
   logic        enable;
   logic [31:0] extended, zero_extended, upper, branch_offset, extended_q;
   logic        valid_q;

   logic [7:0]  imm8;
   logic [7:0]  ext8, zext8, upper8, boff8, ext8_q;
   logic        valid8_q;

   int compared;
   int mismatched;

   typedef struct {
      logic [15:0] in;
      logic [31:0] ext;
      logic [31:0] zext;
      logic [31:0] up;
      logic [31:0] boff;
   } vec_t;

   vec_t vectors[6];

   ext_signo_unit dut (
      .i_clock         (clock),
      .i_reset         (reset_n),
      .i_unextended    (imm),
      .i_enable        (enable),
      .o_extended      (extended),
      .o_zero_extended (zero_extended),
      .o_upper         (upper),
      .o_branch_offset (branch_offset),
      .o_extended_q    (extended_q),
      .o_valid_q       (valid_q)
   );

   ext_signo_unit #(.NB_UNEXTEND(8), .NB_EXTEND(8)) dut8 (
      .i_clock         (clock),
      .i_reset         (reset_n),
      .i_unextended    (imm8),
      .i_enable        (enable),
      .o_extended      (ext8),
      .o_zero_extended (zext8),
      .o_upper         (upper8),
      .o_branch_offset (boff8),
      .o_extended_q    (ext8_q),
      .o_valid_q       (valid8_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] value, input logic en, input logic rst_n);
      imm     = value;
      enable  = en;
      reset_n = rst_n;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [15:0]        rnd;
      logic signed [31:0] model;

      compared   = 0;
      mismatched = 0;
      imm8       = 8'h00;

      vectors[0] = '{16'h0FFF, 32'h00000FFF, 32'h00000FFF, 32'h0FFF0000, 32'h00003FFC};
      vectors[1] = '{16'hFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFC};
      vectors[2] = '{16'h7000, 32'h00007000, 32'h00007000, 32'h70000000, 32'h0001C000};
      vectors[3] = '{16'h8000, 32'hFFFF8000, 32'h00008000, 32'h80000000, 32'hFFFE0000};
      vectors[4] = '{16'h0000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
      vectors[5] = '{16'h0001, 32'h00000001, 32'h00000001, 32'h00010000, 32'h00000004};

      $display("[TB] combinational vector table (reset held low)");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vectors[i].in, 1'b0, 1'b0);
         checkOutput($sformatf("ext[%0d]", i),  extended,      vectors[i].ext);
         checkOutput($sformatf("zext[%0d]", i), zero_extended, vectors[i].zext);
         checkOutput($sformatf("up[%0d]", i),   upper,         vectors[i].up);
         checkOutput($sformatf("boff[%0d]", i), branch_offset, vectors[i].boff);
      end

      $display("[TB] 8-bit pass-through instance");
      imm8 = 8'h80;
      #1;
      checkOutput("ext8",  {24'h0, ext8},   32'h00000080);
      checkOutput("up8",   {24'h0, upper8}, 32'h00000080);
      checkOutput("zext8", {24'h0, zext8},  32'h00000080);
      checkOutput("boff8", {24'h0, boff8},  32'h00000000);

      $display("[TB] reset held two cycles with enable high");
      applyStimulus(16'hFFFF, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("rst_q",     extended_q,       32'h00000000);
      checkOutput("rst_valid", {31'h0, valid_q}, 32'h00000000);

      applyStimulus(16'hFFFF, 1'b1, 1'b1);
      tick();
      checkOutput("load_q",     extended_q,       32'hFFFFFFFF);
      checkOutput("load_valid", {31'h0, valid_q}, 32'h00000001);

      $display("[TB] one-cycle latency and hold while disabled");
      applyStimulus(16'h0001, 1'b1, 1'b1);
      checkOutput("pre_edge_q", extended_q, 32'hFFFFFFFF);
      tick();
      checkOutput("load1_q", extended_q, 32'h00000001);
      applyStimulus(16'h8000, 1'b0, 1'b1);
      checkOutput("track_ext", extended, 32'hFFFF8000);
      tick();
      checkOutput("hold_q",     extended_q,       32'h00000001);
      checkOutput("hold_valid", {31'h0, valid_q}, 32'h00000000);
      tick();
      checkOutput("hold2_q", extended_q, 32'h00000001);

      $display("[TB] reset mid-stream beats enable");
      applyStimulus(16'h8000, 1'b1, 1'b1);
      tick();
      checkOutput("load8000_q", extended_q, 32'hFFFF8000);
      applyStimulus(16'h7000, 1'b1, 1'b0);
      tick();
      checkOutput("midrst_q",     extended_q,       32'h00000000);
      checkOutput("midrst_valid", {31'h0, valid_q}, 32'h00000000);

      $display("[TB] random sweep");
      applyStimulus(16'h0000, 1'b1, 1'b1);
      for (int i = 0; i < 1000; i++) begin
         rnd = 16'($urandom_range(0, 16'hFFFF));
         applyStimulus(rnd, 1'b1, 1'b1);
         model = 32'($signed(rnd));
         checkOutput("sweep_ext", extended, model);
         tick();
         checkOutput("sweep_q", extended_q, model);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
